// File: rtl/key_press_gen.sv
// Push-button waveform synthesiser: turns one-cycle short/long press requests into a
// bounced press, a held level, a bounced release and a mandatory released gap on out_key.
module key_press_gen #(
   parameter int IN_C_HZ      = 50_000_000,
   parameter int SHORT_MS     = 50,
   parameter int LONG_MS      = 1000,
   parameter int GAP_MS       = 100,
   parameter int BOUNCE_EDGES = 4,
   parameter int BOUNCE_CYC   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_short,
   input  logic req_long,
   output logic busy,
   output logic done,
   output logic req_drop,
   output logic out_key
);

   localparam int CPMS    = IN_C_HZ / 1000;
   localparam int H_SHORT = SHORT_MS * CPMS;
   localparam int H_LONG  = LONG_MS * CPMS;
   localparam int G_CYC   = GAP_MS * CPMS;
   localparam int MAX_A   = (H_LONG > G_CYC) ? H_LONG : G_CYC;
   localparam int MAX_C   = (MAX_A > BOUNCE_CYC) ? MAX_A : BOUNCE_CYC;
   localparam int CW      = (MAX_C > 0) ? $clog2(MAX_C + 1) : 1;
   localparam int SW      = (BOUNCE_EDGES > 1) ? $clog2(BOUNCE_EDGES) : 1;
   localparam bit HAS_BOUNCE = (BOUNCE_EDGES > 0);

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] HS_M1    = CW'(H_SHORT - 1);
   localparam logic [CW-1:0] HL_M1    = CW'(H_LONG - 1);
   localparam logic [CW-1:0] G_M1     = CW'(G_CYC - 1);
   localparam logic [CW-1:0] BC_M1    = CW'(BOUNCE_CYC - 1);
   localparam logic [SW-1:0] SEG_ONE  = SW'(1);
   localparam logic [SW-1:0] SEG_LAST = SW'(BOUNCE_EDGES - 1);

   if (!(SHORT_MS > 0 && SHORT_MS < LONG_MS && GAP_MS >= 1 && BOUNCE_CYC >= 1 &&
         BOUNCE_EDGES >= 0)) begin : g_param_check
      $error("key_press_gen: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_BOUNCE_IN,
      S_HOLD,
      S_BOUNCE_OUT,
      S_GAP
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] hold_m1, hold_m1_n;
   logic [SW-1:0] seg, seg_n;
   logic          busy_n, done_n, drop_n, key_n;
   logic          any_req;

   assign any_req = req_short | req_long;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         seg      <= '0;
         hold_m1  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         req_drop <= 1'b0;
         out_key  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         seg      <= seg_n;
         hold_m1  <= hold_m1_n;
         busy     <= busy_n;
         done     <= done_n;
         req_drop <= drop_n;
         out_key  <= key_n;
      end
   end

   // Outputs are decoded from the next state so every output is a plain register.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CNT_ONE;
      seg_n     = seg;
      hold_m1_n = hold_m1;
      done_n    = 1'b0;
      unique case (state)
         S_IDLE: begin
            cnt_n = '0;
            seg_n = '0;
            if (any_req) begin
               hold_m1_n = req_long ? HL_M1 : HS_M1;
               state_n   = HAS_BOUNCE ? S_BOUNCE_IN : S_HOLD;
            end
         end
         S_BOUNCE_IN: begin
            if (cnt == BC_M1) begin
               cnt_n = '0;
               seg_n = seg + SEG_ONE;
               if (seg == SEG_LAST) begin
                  seg_n   = '0;
                  state_n = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (cnt == hold_m1) begin
               cnt_n   = '0;
               seg_n   = '0;
               state_n = HAS_BOUNCE ? S_BOUNCE_OUT : S_GAP;
            end
         end
         S_BOUNCE_OUT: begin
            if (cnt == BC_M1) begin
               cnt_n = '0;
               seg_n = seg + SEG_ONE;
               if (seg == SEG_LAST) begin
                  seg_n   = '0;
                  state_n = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (cnt == G_M1) begin
               cnt_n   = '0;
               state_n = S_IDLE;
               done_n  = 1'b1;
            end
         end
         default: begin
            cnt_n   = '0;
            seg_n   = '0;
            state_n = S_IDLE;
         end
      endcase

      case (state_n)
         S_BOUNCE_IN:  key_n = ~seg_n[0];
         S_HOLD:       key_n = 1'b1;
         S_BOUNCE_OUT: key_n = seg_n[0];
         default:      key_n = 1'b0;
      endcase
      busy_n = (state_n != S_IDLE);
      drop_n = (state != S_IDLE) && any_req;
   end

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen: a bounced instance and a bounce-free instance, checked each
// cycle against a position-in-sequence model plus directed anchor values.
module tb_key_press_gen;

   localparam int BC = 2;
   localparam int HS = 5;
   localparam int HL = 20;
   localparam int G  = 3;

   logic       clk = 1'b0;
   logic [1:0] rs_v = '0, rl_v = '0, rn_v = '0;
   logic [1:0] busy_v, done_v, drop_v, key_v;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int pos[2];
   bit lng[2], ek[2], eb[2], ed[2], edr[2];
   logic [15:0] short_tr;

   always #5 clk = ~clk;

   key_press_gen #(.IN_C_HZ(1000), .SHORT_MS(HS), .LONG_MS(HL), .GAP_MS(G),
                   .BOUNCE_EDGES(2), .BOUNCE_CYC(BC)) dut_b (
      .clk(clk), .rst_n(rn_v[0]), .req_short(rs_v[0]), .req_long(rl_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .req_drop(drop_v[0]), .out_key(key_v[0]));

   key_press_gen #(.IN_C_HZ(1000), .SHORT_MS(HS), .LONG_MS(HL), .GAP_MS(G),
                   .BOUNCE_EDGES(0), .BOUNCE_CYC(BC)) dut_n (
      .clk(clk), .rst_n(rn_v[1]), .req_short(rs_v[1]), .req_long(rl_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .req_drop(drop_v[1]), .out_key(key_v[1]));

   // Key level at offset p of a sequence with hold h and e bounce segments per transition.
   function automatic bit key_at(int p, int h, int e);
      int b;
      b = e * BC;
      if (p < b) return ((p / BC) % 2) == 0;
      if (p < b + h) return 1'b1;
      if (p < 2 * b + h) return ((p - b - h) / BC) % 2 == 1;
      return 1'b0;
   endfunction

   task automatic modelEdge(input int d);
      int e, h, len;
      bit req;
      e   = (d == 0) ? 2 : 0;
      req = rs_v[d] | rl_v[d];
      if (!rn_v[d]) begin
         pos[d] = -1;
         ed[d]  = 1'b0;
         edr[d] = 1'b0;
      end else begin
         edr[d] = (pos[d] >= 0) && req;
         ed[d]  = 1'b0;
         if (pos[d] >= 0) begin
            h   = lng[d] ? HL : HS;
            len = 2 * e * BC + h + G;
            if (pos[d] == len - 1) begin
               pos[d] = -1;
               ed[d]  = 1'b1;
            end else begin
               pos[d] = pos[d] + 1;
            end
         end else if (req) begin
            lng[d] = rl_v[d];
            pos[d] = 0;
         end
      end
      h     = lng[d] ? HL : HS;
      ek[d] = (pos[d] >= 0) ? key_at(pos[d], h, e) : 1'b0;
      eb[d] = (pos[d] >= 0);
   endtask

   task automatic check1(input string tag, input int d, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s dut%0d cyc=%0d got=%b want=%b", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic checkOutput();
      for (int d = 0; d < 2; d++) begin
         check1("out_key", d, key_v[d], ek[d]);
         check1("busy", d, busy_v[d], eb[d]);
         check1("done", d, done_v[d], ed[d]);
         check1("req_drop", d, drop_v[d], edr[d]);
      end
   endtask

   // Drives one cycle of inputs, then checks the outputs of the following cycle.
   task automatic applyStimulus(input logic s0, l0, n0, s1, l1, n1);
      @(negedge clk);
      rs_v = {s1, s0};
      rl_v = {l1, l0};
      rn_v = {n1, n0};
      @(posedge clk);
      modelEdge(0);
      modelEdge(1);
      #1;
      cyc++;
      checkOutput();
   endtask

   task automatic idleStep();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      pos[0] = -1;
      pos[1] = -1;
      short_tr = 16'b1100_11111_0011_000;

      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check1("rst_key", 0, key_v[0], 1'b0);
      check1("rst_busy", 1, busy_v[1], 1'b0);
      repeat (2) idleStep();

      $display("[TB] short press");
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check1("short_trace", 0, key_v[0], short_tr[16 - cyc]);
      repeat (15) begin
         idleStep();
         check1("short_trace", 0, key_v[0], short_tr[16 - cyc]);
      end
      idleStep();
      check1("short_done", 0, done_v[0], 1'b1);
      check1("short_idle", 0, busy_v[0], 1'b0);

      $display("[TB] long press");
      cyc = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      while (cyc < 32) begin
         idleStep();
         if (cyc == 4) check1("long_bounce", 0, key_v[0], 1'b0);
         if (cyc == 24) check1("long_hold_end", 0, key_v[0], 1'b1);
         if (cyc == 25) check1("long_release", 0, key_v[0], 1'b0);
      end
      check1("long_done", 0, done_v[0], 1'b1);

      $display("[TB] simultaneous requests");
      cyc = 0;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      while (cyc < 32) begin
         idleStep();
         if (cyc == 24) check1("both_hold_end", 0, key_v[0], 1'b1);
         check1("both_nodrop", 0, drop_v[0], 1'b0);
      end
      check1("both_done", 0, done_v[0], 1'b1);

      $display("[TB] request while busy");
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      while (cyc < 6) idleStep();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check1("drop_pulse", 0, drop_v[0], 1'b1);
      idleStep();
      check1("drop_single", 0, drop_v[0], 1'b0);
      while (cyc < 17) idleStep();
      check1("drop_done", 0, done_v[0], 1'b1);

      $display("[TB] back-to-back");
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      while (cyc < 17) idleStep();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check1("b2b_start", 0, key_v[0], 1'b1);
      check1("b2b_nodrop", 0, drop_v[0], 1'b0);
      while (cyc < 34) idleStep();
      check1("b2b_done", 0, done_v[0], 1'b1);

      $display("[TB] reset mid-hold");
      cyc = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      while (cyc < 10) idleStep();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check1("rst_mid_key", 0, key_v[0], 1'b0);
      check1("rst_mid_busy", 0, busy_v[0], 1'b0);
      repeat (30) idleStep();
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      while (cyc < 17) idleStep();
      check1("rst_after_done", 0, done_v[0], 1'b1);

      $display("[TB] no-bounce variant");
      cyc = 0;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      check1("nb_key", 1, key_v[1], 1'b1);
      while (cyc < 6) idleStep();
      check1("nb_gap", 1, key_v[1], 1'b0);
      while (cyc < 9) idleStep();
      check1("nb_done", 1, done_v[1], 1'b1);

      $display("[TB] random traffic");
      repeat (1500) begin
         applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 299) != 0,
                       $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 299) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
